alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_core.sv | 30 +++
 rtl/alu_exec.sv | 114 +++++++++++
 tb/tb_alu_exec.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU execute block: operation codes, FSM states, decode helper.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam int unsigned SHAMT_W = 5;

  // True for the three serial shift operations.
  function automatic logic is_shift(logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU; shift codes pass operand A through as the shift seed.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: result = WIDTH'(a < b);
      ALU_SLL, ALU_SRL, ALU_SRA: result = a;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage with valid/ready handshakes; shifts run serially one bit per cycle.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  state_t               state, state_next;
  alu_op_t              op_q;
  logic [SHAMT_W-1:0]   cnt;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     core_result;
  logic                 core_illegal;
  logic [WIDTH-1:0]     step;
  logic                 accept;
  logic                 go_shift;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op      (ALUControl),
    .a       (a),
    .b       (b),
    .result  (core_result),
    .illegal (core_illegal)
  );

  assign shamt    = b[SHAMT_W-1:0];
  assign accept   = in_valid & in_ready;
  assign go_shift = is_shift(ALUControl) && (shamt != '0);

  // One-bit shift step applied to the in-flight value held in result.
  always_comb begin
    step = result;
    case (op_q)
      ALU_SLL: step = {result[WIDTH-2:0], 1'b0};
      ALU_SRL: step = {1'b0, result[WIDTH-1:1]};
      ALU_SRA: step = {result[WIDTH-1], result[WIDTH-1:1]};
      default: step = result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (in_valid) state_next = go_shift ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (cnt == SHAMT_W'(1)) state_next = ST_DONE;
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Result path: captured at acceptance, then stepped while shifting, frozen in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      cnt     <= '0;
      op_q    <= ALU_ADD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (go_shift) begin
              result  <= a;
              cnt     <= shamt;
              op_q    <= alu_op_t'(ALUControl);
              zero    <= 1'b0;
              illegal <= 1'b0;
            end else begin
              result  <= core_result;
              zero    <= (core_result == '0);
              illegal <= core_illegal;
            end
          end
        end
        ST_SHIFT: begin
          result <= step;
          cnt    <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) zero <= (step == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, reset/abort sequences, random ops vs reference model.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          stall;
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  // Reference: {illegal, result} computed straight from the operation definitions.
  function automatic logic [32:0] ref_alu(logic [3:0] op, logic [31:0] x, logic [31:0] y);
    logic [4:0] sh;
    sh = y[4:0];
    case (op)
      4'd0:    return {1'b0, x + y};
      4'd1:    return {1'b0, x - y};
      4'd2:    return {1'b0, x & y};
      4'd3:    return {1'b0, x | y};
      4'd4:    return {1'b0, x ^ y};
      4'd5:    return {1'b0, (($signed(x) < $signed(y)) ? 32'd1 : 32'd0)};
      4'd6:    return {1'b0, ((x < y) ? 32'd1 : 32'd0)};
      4'd7:    return {1'b0, x << sh};
      4'd8:    return {1'b0, x >> sh};
      4'd9:    return {1'b0, 32'($signed(x) >>> sh)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic int ref_lat(logic [3:0] op, logic [31:0] y);
    if (op >= 4'd7 && op <= 4'd9 && y[4:0] != 5'd0) return int'(y[4:0]) + 1;
    return 1;
  endfunction

  // Issue one op, measure latency, hold out_ready low for 'stall' cycles, then complete.
  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input int stall, output logic [31:0] res, output logic z,
                        output logic il, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    ALUControl = op;
    a          = av;
    b          = bv;
    out_ready  = (stall == 0);
    @(negedge clk);
    in_valid   = 1'b0;
    ALUControl = 4'($urandom);
    a          = $urandom;
    b          = $urandom;
    check("in_ready_low_after_accept", 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_rose", 32'(out_valid), 32'd1);
    res = result;
    z   = zero;
    il  = illegal;
    for (int i = 0; i < stall; i++) begin
      in_valid   = 1'b1;
      ALUControl = 4'($urandom);
      @(negedge clk);
      check("stall_result_stable", result, res);
      check("stall_flags_stable", {30'd0, zero, illegal}, {30'd0, z, il});
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_hs_out_valid_low", 32'(out_valid), 32'd0);
    check("post_hs_in_ready_high", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        z;
    logic        il;
    int          lat;
    logic [32:0] exp;
    logic [3:0]  op;
    logic [31:0] av;
    logic [31:0] bv;
    int          seen;

    vecs[0]  = '{4'd0,  32'd5,          32'd7,          0, 32'd12,         1'b0, 1'b0, 1};
    vecs[1]  = '{4'd1,  32'd9,          32'd9,          0, 32'd0,          1'b1, 1'b0, 1};
    vecs[2]  = '{4'd5,  32'hFFFF_FFFF,  32'd1,          0, 32'd1,          1'b0, 1'b0, 1};
    vecs[3]  = '{4'd6,  32'hFFFF_FFFF,  32'd1,          0, 32'd0,          1'b1, 1'b0, 1};
    vecs[4]  = '{4'd9,  32'h8000_0000,  32'd4,          0, 32'hF800_0000,  1'b0, 1'b0, 5};
    vecs[5]  = '{4'd8,  32'h8000_0000,  32'd4,          0, 32'h0800_0000,  1'b0, 1'b0, 5};
    vecs[6]  = '{4'd3,  32'h0000_00F0,  32'h0000_000F,  3, 32'h0000_00FF,  1'b0, 1'b0, 1};
    vecs[7]  = '{4'd15, 32'h0000_1234,  32'd5,          0, 32'd0,          1'b1, 1'b1, 1};
    vecs[8]  = '{4'd7,  32'h1234_5678,  32'h0000_0020,  0, 32'h1234_5678,  1'b0, 1'b0, 1};
    vecs[9]  = '{4'd9,  32'h8000_0000,  32'd31,         1, 32'hFFFF_FFFF,  1'b0, 1'b0, 32};
    vecs[10] = '{4'd7,  32'h0000_0003,  32'd31,         0, 32'h8000_0000,  1'b0, 1'b0, 32};
    vecs[11] = '{4'd4,  32'hFFFF_0000,  32'hFFFF_0000,  0, 32'd0,          1'b1, 1'b0, 1};
    vecs[12] = '{4'd2,  32'h0000_F0F0,  32'h0000_0FF0,  2, 32'h0000_00F0,  1'b0, 1'b0, 1};
    vecs[13] = '{4'd10, 32'hDEAD_BEEF,  32'h1,          0, 32'd0,          1'b1, 1'b1, 1};

    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ALUControl = 4'd0;
    a          = '0;
    b          = '0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_flags", {30'd0, zero, illegal}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].stall, r, z, il, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].zero));
      check($sformatf("vec%0d_illegal", i), 32'(il), 32'(vecs[i].ill));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Reset during the third SHIFT cycle of sll 1<<31 must drop the operation.
    in_valid   = 1'b1;
    ALUControl = 4'd7;
    a          = 32'd1;
    b          = 32'd31;
    out_ready  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_result_cleared", result, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort_no_out_valid", 32'(seen), 32'd0);
    out_ready = 1'b0;
    run_op(4'd0, 32'd2, 32'd2, 0, r, z, il, lat);
    check("abort_next_add", r, 32'd4);
    check("abort_next_lat", 32'(lat), 32'd1);

    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      av = $urandom;
      bv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      exp = ref_alu(op, av, bv);
      run_op(op, av, bv, $urandom_range(0, 2), r, z, il, lat);
      check($sformatf("rnd%0d_op%0d_result", n, op), r, exp[31:0]);
      check($sformatf("rnd%0d_zero", n), 32'(z), 32'(exp[31:0] == 32'd0));
      check($sformatf("rnd%0d_illegal", n), 32'(il), 32'(exp[32]));
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(ref_lat(op, bv)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
